// File: rtl/coord_stepper_if.sv
// Frame-parameter / raster-timing inputs and pixel-coordinate outputs of coord_stepper.
interface coord_stepper_if #(
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned ZOOM_WIDTH  = 8,
  parameter int unsigned ITER_WIDTH  = 6
);
  logic                   v_begin;
  logic                   h_begin;
  logic                   pix_en;
  logic [COORD_WIDTH-1:0] centre_x;
  logic [COORD_WIDTH-1:0] centre_y;
  logic [ZOOM_WIDTH-1:0]  zoom_level;
  logic [ITER_WIDTH-1:0]  max_iter_limit;
  logic [COORD_WIDTH-1:0] c_re;
  logic [COORD_WIDTH-1:0] c_im;
  logic                   c_valid;
  logic [ITER_WIDTH-1:0]  frame_iter_limit;
  logic                   overrun_err;

  modport master (
    output v_begin, h_begin, pix_en, centre_x, centre_y, zoom_level, max_iter_limit,
    input  c_re, c_im, c_valid, frame_iter_limit, overrun_err
  );

  modport slave (
    input  v_begin, h_begin, pix_en, centre_x, centre_y, zoom_level, max_iter_limit,
    output c_re, c_im, c_valid, frame_iter_limit, overrun_err
  );
endinterface

// File: rtl/coord_stepper.sv
// Per-pixel Q4.12 complex-plane coordinate generator using incremental accumulators.
// Optional macro COORD_SAT_EN: adds an accumulator guard bit and saturates the output coordinates.
module coord_stepper #(
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned ZOOM_WIDTH  = 8,
  parameter int unsigned ITER_WIDTH  = 6,
  parameter int unsigned EXT_BITS    = 8,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned BASE_STEP   = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  coord_stepper_if.slave bus
);

  localparam int unsigned A = COORD_WIDTH + EXT_BITS;
`ifdef COORD_SAT_EN
  localparam int unsigned AW = A + 1;
`else
  localparam int unsigned AW = A;
`endif
  localparam int unsigned CNT_W = $clog2(H_ACTIVE + 1);
  localparam logic [AW-1:0] STEP0 = AW'(BASE_STEP) << EXT_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [COORD_WIDTH-1:0] r_cx;
  logic [COORD_WIDTH-1:0] r_cy;
  logic [ZOOM_WIDTH-1:0]  r_zoom;
  logic [ITER_WIDTH-1:0]  r_iter;
  logic [AW-1:0]          r_step;
  logic [AW-1:0]          r_org_re;
  logic [AW-1:0]          r_org_im;
  logic [AW-1:0]          r_re_acc;
  logic [AW-1:0]          r_im_acc;
  logic                   r_first_line;
  logic [CNT_W-1:0]       r_pix_cnt;
  logic [COORD_WIDTH-1:0] r_c_re;
  logic [COORD_WIDTH-1:0] r_c_im;
  logic                   r_c_valid;
  logic                   r_overrun;

  logic [3:0]             w_z;
  logic [AW-1:0]          w_step;
  logic [AW-1:0]          w_org_re;
  logic [AW-1:0]          w_org_im;
  logic                   w_hb;
  logic                   w_pe;
  logic [AW-1:0]          w_re_base;
  logic [AW-1:0]          w_im_base;
  logic [CNT_W-1:0]       w_cnt_base;
  logic [COORD_WIDTH-1:0] w_re_out;
  logic [COORD_WIDTH-1:0] w_im_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.v_begin) begin
      w_state_nxt = S_LOAD;
    end else begin
      unique case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_LOAD:  w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame geometry from the parameters latched at v_begin.
  always_comb begin
    w_z      = (r_zoom > ZOOM_WIDTH'(15)) ? 4'd15 : r_zoom[3:0];
    w_step   = STEP0 >> w_z;
    w_org_re = ({{(AW-COORD_WIDTH){r_cx[COORD_WIDTH-1]}}, r_cx} << EXT_BITS)
             - AW'(H_ACTIVE / 2) * w_step;
    w_org_im = ({{(AW-COORD_WIDTH){r_cy[COORD_WIDTH-1]}}, r_cy} << EXT_BITS)
             - AW'(V_ACTIVE / 2) * w_step;
  end

  // h_begin is applied before a coincident pix_en, so the pixel sees the line-start values.
  always_comb begin
    w_hb       = (r_state == S_RUN) && bus.h_begin && !bus.v_begin;
    w_pe       = (r_state == S_RUN) && bus.pix_en  && !bus.v_begin;
    w_re_base  = w_hb ? r_org_re : r_re_acc;
    w_im_base  = w_hb ? (r_first_line ? r_org_im : r_im_acc + r_step) : r_im_acc;
    w_cnt_base = w_hb ? '0 : r_pix_cnt;
  end

  always_comb begin
`ifdef COORD_SAT_EN
    w_re_out = (w_re_base[AW-1] != w_re_base[AW-2])
             ? {w_re_base[AW-1], {(COORD_WIDTH-1){~w_re_base[AW-1]}}}
             : w_re_base[AW-2:EXT_BITS];
    w_im_out = (w_im_base[AW-1] != w_im_base[AW-2])
             ? {w_im_base[AW-1], {(COORD_WIDTH-1){~w_im_base[AW-1]}}}
             : w_im_base[AW-2:EXT_BITS];
`else
    w_re_out = w_re_base[A-1:EXT_BITS];
    w_im_out = w_im_base[A-1:EXT_BITS];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx         <= '0;
      r_cy         <= '0;
      r_zoom       <= '0;
      r_iter       <= '1;
      r_step       <= '0;
      r_org_re     <= '0;
      r_org_im     <= '0;
      r_re_acc     <= '0;
      r_im_acc     <= '0;
      r_first_line <= 1'b0;
      r_pix_cnt    <= '0;
      r_c_re       <= '0;
      r_c_im       <= '0;
      r_c_valid    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_c_valid <= w_pe;
      if (bus.v_begin) begin
        r_cx      <= bus.centre_x;
        r_cy      <= bus.centre_y;
        r_zoom    <= bus.zoom_level;
        r_iter    <= bus.max_iter_limit;
        r_overrun <= 1'b0;
      end else if (r_state == S_LOAD) begin
        r_step       <= w_step;
        r_org_re     <= w_org_re;
        r_org_im     <= w_org_im;
        r_first_line <= 1'b1;
        r_pix_cnt    <= '0;
      end else if (w_hb || w_pe) begin
        r_im_acc <= w_im_base;
        if (w_hb) r_first_line <= 1'b0;
        if (w_pe) begin
          r_c_re   <= w_re_out;
          r_c_im   <= w_im_out;
          r_re_acc <= w_re_base + r_step;
          // Counter parks at H_ACTIVE so long overruns cannot wrap it back into range.
          if (w_cnt_base == CNT_W'(H_ACTIVE)) begin
            r_overrun <= 1'b1;
            r_pix_cnt <= w_cnt_base;
          end else begin
            r_pix_cnt <= w_cnt_base + CNT_W'(1);
          end
        end else begin
          r_re_acc  <= w_re_base;
          r_pix_cnt <= w_cnt_base;
        end
      end
    end
  end

  assign bus.c_re             = r_c_re;
  assign bus.c_im             = r_c_im;
  assign bus.c_valid          = r_c_valid;
  assign bus.frame_iter_limit = r_iter;
  assign bus.overrun_err      = r_overrun;

endmodule

// File: tb/tb_coord_stepper.sv
// Directed bench for coord_stepper with a coordinate scoreboard and an independent closed-form model.
module tb_coord_stepper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  coord_stepper_if #(.COORD_WIDTH(16), .ZOOM_WIDTH(8), .ITER_WIDTH(6)) bus ();

  coord_stepper #(
    .COORD_WIDTH(16), .ZOOM_WIDTH(8), .ITER_WIDTH(6), .EXT_BITS(8),
    .H_ACTIVE(640), .V_ACTIVE(480), .BASE_STEP(19)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [15:0] m_cx, m_cy;
  logic [7:0]  m_zoom;
  int          m_line, m_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Closed form: floor((c*2^8 - half*step + idx*step) / 2^8), wrapped to 16 bits.
  function automatic logic [15:0] model(input logic [15:0] c, input int idx, input int half);
    longint step, v;
    int z;
    z    = (m_zoom > 8'd15) ? 15 : int'(m_zoom);
    step = (longint'(19) * 256) >>> z;
    v    = longint'($signed(c)) * 256 - longint'(half) * step + longint'(idx) * step;
    return 16'(v >>> 8);
  endfunction

  task automatic cyc(input logic v, input logic h, input logic p);
    bus.v_begin = v;
    bus.h_begin = h;
    bus.pix_en  = p;
    @(posedge clk);
    #1;
    bus.v_begin = 1'b0;
    bus.h_begin = 1'b0;
    bus.pix_en  = 1'b0;
  endtask

  task automatic set_params(input logic [15:0] cx, input logic [15:0] cy,
                            input logic [7:0] z, input logic [5:0] it);
    bus.centre_x       = cx;
    bus.centre_y       = cy;
    bus.zoom_level     = z;
    bus.max_iter_limit = it;
  endtask

  task automatic vb(input logic [15:0] cx, input logic [15:0] cy,
                    input logic [7:0] z, input logic [5:0] it);
    set_params(cx, cy, z, it);
    m_cx = cx; m_cy = cy; m_zoom = z; m_line = -1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("iter_latch", 32'(bus.frame_iter_limit), 32'(it));
    chk("overrun_clr", 32'(bus.overrun_err), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("load_no_valid", 32'(bus.c_valid), 32'd0);
  endtask

  task automatic hb();
    m_line++;
    m_n = 0;
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic pix();
    exp_q.push_back({model(m_cx, m_n, 320), model(m_cy, m_line, 240)});
    m_n++;
    cyc(1'b0, 1'b0, 1'b1);
    chk("valid_lat", 32'(bus.c_valid), 32'd1);
  endtask

  task automatic pix_lit(input logic [15:0] re, input logic [15:0] im);
    exp_q.push_back({re, im});
    m_n++;
    cyc(1'b0, 1'b0, 1'b1);
    chk("valid_lat", 32'(bus.c_valid), 32'd1);
  endtask

  task automatic hb_pix();
    m_line++;
    m_n = 0;
    exp_q.push_back({model(m_cx, m_n, 320), model(m_cy, m_line, 240)});
    m_n++;
    cyc(1'b0, 1'b1, 1'b1);
    chk("hb_pix_valid", 32'(bus.c_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    if (bus.c_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_valid observed re=%h im=%h expected no coordinate",
               bus.c_re, bus.c_im);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("c_re", {16'h0, bus.c_re}, {16'h0, e[31:16]});
        chk("c_im", {16'h0, bus.c_im}, {16'h0, e[15:0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.v_begin = 1'b0; bus.h_begin = 1'b0; bus.pix_en = 1'b0;
    set_params(16'h0, 16'h0, 8'h0, 6'h0);
    m_cx = '0; m_cy = '0; m_zoom = '0; m_line = -1; m_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c_re", 32'(bus.c_re), 32'd0);
    chk("rst_c_im", 32'(bus.c_im), 32'd0);
    chk("rst_valid", 32'(bus.c_valid), 32'd0);
    chk("rst_iter", 32'(bus.frame_iter_limit), 32'h3F);
    chk("rst_overrun", 32'(bus.overrun_err), 32'd0);
    rst_n = 1'b1;

    cyc(1'b0, 1'b1, 1'b1);
    chk("idle_ignore", 32'(bus.c_valid), 32'd0);

    vb(16'hF000, 16'h0000, 8'd0, 6'd20);
    hb();
    pix_lit(16'hD840, 16'hEE30);
    pix_lit(16'hD853, 16'hEE30);
    cyc(1'b0, 1'b0, 1'b0);
    chk("valid_drop", 32'(bus.c_valid), 32'd0);
    chk("hold_re", 32'(bus.c_re), 32'hD853);
    hb();
    pix_lit(16'hD840, 16'hEE43);
    pix();
    hb_pix();
    pix();

    set_params(16'h1000, 16'h0300, 8'd3, 6'd7);
    hb();
    pix();
    pix();
    chk("iter_hold", 32'(bus.frame_iter_limit), 32'd20);

    vb(16'hF000, 16'h0000, 8'd4, 6'd7);
    hb();
    pix_lit(16'hEE84, 16'hFEE3);
    pix_lit(16'hEE85, 16'hFEE3);
    pix();

    vb(16'h1000, 16'h0800, 8'd3, 6'd33);
    hb(); pix(); pix(); pix();
    hb(); pix();
    hb_pix(); pix();

    hb();
    repeat (640) pix();
    cyc(1'b0, 1'b0, 1'b0);
    chk("no_overrun_640", 32'(bus.overrun_err), 32'd0);
    pix();
    chk("overrun_641", 32'(bus.overrun_err), 32'd1);
    pix();
    chk("overrun_sticky", 32'(bus.overrun_err), 32'd1);

    set_params(16'h0123, 16'h0456, 8'd200, 6'd5);
    m_cx = 16'h0123; m_cy = 16'h0456; m_zoom = 8'd200; m_line = -1;
    cyc(1'b1, 1'b1, 1'b1);
    chk("vb_wins_valid", 32'(bus.c_valid), 32'd0);
    chk("vb_wins_overrun", 32'(bus.overrun_err), 32'd0);
    chk("vb_wins_iter", 32'(bus.frame_iter_limit), 32'd5);
    cyc(1'b0, 1'b0, 1'b1);
    chk("load_pix_drop", 32'(bus.c_valid), 32'd0);
    hb();
    pix_lit(16'h0123, 16'h0456);
    pix_lit(16'h0123, 16'h0456);
    hb();
    pix_lit(16'h0123, 16'h0456);

    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coord_stepper.md
Name: coord_stepper

Overview:
- Consumer of the frame parameters: centre_x, centre_y, zoom_level and max_iter_limit.
- Latches the parameters once per frame and converts the raster pixel sequence into per-pixel complex-plane coordinates (c_re, c_im, Q4.12) for the iteration engine.
- Uses incremental accumulators, so there is no per-pixel multiply.
- Sits between the parameter controller and VGA timing on one side, and the Mandelbrot iteration core on the other.

Parameters:
- COORD_WIDTH, 16, coordinate width, Q4.12 two's complement
- ZOOM_WIDTH, 8, zoom_level width
- ITER_WIDTH, 6, iteration-limit width
- EXT_BITS, 8, extra fraction bits carried in the internal accumulators
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BASE_STEP, 19, per-pixel step at zoom 0, in Q4.12 LSBs (≈0.00464)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- v_begin  in  1  one-cycle strobe, frame start
- h_begin  in  1  one-cycle strobe, before the first active pixel of each line
- pix_en  in  1  advance strobe, one per active pixel
- centre_x  in  COORD_WIDTH  signed frame centre, real part
- centre_y  in  COORD_WIDTH  signed frame centre, imaginary part
- zoom_level  in  ZOOM_WIDTH  zoom exponent
- max_iter_limit  in  ITER_WIDTH  iteration limit requested for the frame
- c_re  out  COORD_WIDTH  signed pixel coordinate, real part
- c_im  out  COORD_WIDTH  signed pixel coordinate, imaginary part
- c_valid  out  1  c_re/c_im valid this cycle
- frame_iter_limit  out  ITER_WIDTH  max_iter_limit latched at frame start
- overrun_err  out  1  sticky: more than H_ACTIVE pix_en seen on one line

Behaviour:
- Reset values:
  - State IDLE.
  - c_re = 0, c_im = 0, c_valid = 0.
  - frame_iter_limit = all-ones.
  - overrun_err = 0.
  - All accumulators = 0.
- Internal accumulator width: A = COORD_WIDTH + EXT_BITS. Output coordinate = acc[A-1:EXT_BITS], truncation only.
- States:
  - IDLE: entered at reset. v_begin -> LOAD. h_begin and pix_en are ignored.
  - LOAD: exactly 1 cycle.
    - Shift count z = min(zoom_level, 15). Use the registered copy latched at v_begin.
    - step = (BASE_STEP << EXT_BITS) >> z.
    - origin_re = (centre_x << EXT_BITS) - (H_ACTIVE/2)*step.
    - origin_im = (centre_y << EXT_BITS) - (V_ACTIVE/2)*step.
    - All operands sign-extended to A bits.
    - Set first_line = 1, clear the pixel counter, then -> RUN.
  - RUN:
    - h_begin:
      - re_acc <= origin_re; pixel counter <= 0.
      - If first_line: im_acc <= origin_im and first_line <= 0.
      - Otherwise: im_acc <= im_acc + step.
    - pix_en:
      - Next cycle: c_valid = 1, c_re = re_acc output bits, c_im = im_acc output bits.
      - re_acc += step; pixel counter += 1.
      - If the counter is already H_ACTIVE, set overrun_err. The coordinate is still issued.
    - No pix_en: c_valid = 0 next cycle; c_re/c_im hold.
- Latency: pix_en -> c_valid is 1 cycle. Back-to-back pix_en gives one coordinate per cycle.
- v_begin, from any state: latches centre_x, centre_y, zoom_level and max_iter_limit (frame_iter_limit updates the next cycle), clears overrun_err, -> LOAD.
  - v_begin mid-line aborts the current line.
  - Parameter changes between v_begin strobes have no effect.
- Simultaneous events:
  - v_begin with h_begin or pix_en: v_begin wins; the others are dropped.
  - h_begin with pix_en: h_begin takes effect first, so the pixel is issued at origin_re and re_acc = origin_re + step.
- pix_en during LOAD: dropped, c_valid = 0.
- pix_en in RUN before the first h_begin: issues from the previous accumulator contents. Test-visible only; there is no error flag for this case.
- Arithmetic wraps modulo 2^A; no saturation in the default build.

Optional Feature:
- Macro: COORD_SAT_EN.
- Defined:
  - Accumulators gain one guard MSB.
  - The output is saturated to [-2^(COORD_WIDTH-1), 2^(COORD_WIDTH-1)-1] (0x8000 / 0x7FFF for 16 bits) when acc exceeds the Q4.12 range.
- Undefined: plain wrap-around truncation, as above.

Test Plan:
- Reset, then v_begin with centre_x = 0xF000, centre_y = 0, zoom = 0, followed by h_begin and 2 pix_en -> c_re = 0xD840 then 0xD853, c_im = 0xEE30, c_valid high 1 cycle after each pix_en.
- Same parameters, a second h_begin -> c_im = 0xEE43; the first pix_en of the line gives c_re = 0xD840.
- v_begin with zoom = 4, centre_x = 0xF000 -> first c_re = 0xEE84; second c_re = 0xEE85 (step 304/256 LSB, with fraction carry).
- Change centre_x and zoom mid-frame without v_begin -> no change to c_re/c_im sequence; after next v_begin the new origin is used; frame_iter_limit follows max_iter_limit only at v_begin.
- 641 pix_en on one line -> overrun_err = 1 after the 641st; v_begin -> overrun_err = 0.
- v_begin together with h_begin and pix_en -> no c_valid that cycle, state LOAD; pix_en during LOAD ignored; zoom = 200 behaves as zoom = 15.
